// File: rtl/masked_write_arbiter_pkg.sv
// Shared types and helpers for the masked write arbiter: grant identity and
// the masked register update function.
package arb_pkg;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

  // Helper operates on a fixed width; callers cast their W-bit values in/out.
  localparam int unsigned MERGE_W = 32;

  function automatic logic [MERGE_W-1:0] merge_masked(
    input logic [MERGE_W-1:0] q,
    input logic [MERGE_W-1:0] d,
    input logic [MERGE_W-1:0] m
  );
    return (q & ~m) | (d & m);
  endfunction

endpackage

// File: rtl/masked_write_arbiter_mask_merge.sv
// Combines the accepted writes of both sources into one mask/data pair
// that feeds the shared register update.
module mask_merge #(
  parameter int unsigned W = 4
) (
  input  logic         a_acc,
  input  logic [W-1:0] a_data,
  input  logic [W-1:0] a_mask,
  input  logic         b_acc,
  input  logic [W-1:0] b_data,
  input  logic [W-1:0] b_mask,
  output logic [W-1:0] m,
  output logic [W-1:0] d
);

  logic [W-1:0] a_mask_acc;
  logic [W-1:0] b_mask_acc;

  assign a_mask_acc = a_acc ? a_mask : '0;
  assign b_mask_acc = b_acc ? b_mask : '0;

  // Masks of simultaneously accepted writes never overlap, so OR-ing is exact.
  assign m = a_mask_acc | b_mask_acc;
  assign d = (a_data & a_mask_acc) | (b_data & b_mask_acc);

endmodule

// File: rtl/masked_write_arbiter.sv
// Single-owner writer for a shared W-bit register updated by field from two
// sources; disjoint writes merge, overlapping writes alternate round-robin.
module masked_write_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [W-1:0]     a_data,
  input  logic [W-1:0]     a_mask,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [W-1:0]     b_data,
  input  logic [W-1:0]     b_mask,
  output logic             b_ready,
  output logic [W-1:0]     q,
  output logic             q_upd,
  output logic             last_gnt,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [W-1:0]     q_r;
  logic             q_upd_r;
  gnt_e             last_gnt_r;
  logic [CNT_W-1:0] conflict_cnt_r;

  logic             ovl;
  logic             a_rdy;
  logic             b_rdy;
  logic             any_acc;
  logic [W-1:0]     merge_m;
  logic [W-1:0]     merge_d;
  logic [W-1:0]     q_next;

  assign ovl = a_valid & b_valid & (|(a_mask & b_mask));

  // Ready depends only on valid, mask, last_gnt and rst -- never on q.
  always_comb begin
    a_rdy = a_valid & ~rst;
    b_rdy = b_valid & ~rst;
    if (ovl) begin
      if (last_gnt_r == GNT_B) begin
        b_rdy = 1'b0;
      end else begin
        a_rdy = 1'b0;
      end
    end
  end

  assign any_acc = a_rdy | b_rdy;

  mask_merge #(
    .W(W)
  ) u_mask_merge (
    .a_acc  (a_rdy),
    .a_data (a_data),
    .a_mask (a_mask),
    .b_acc  (b_rdy),
    .b_data (b_data),
    .b_mask (b_mask),
    .m      (merge_m),
    .d      (merge_d)
  );

  assign q_next = W'(merge_masked(MERGE_W'(q_r), MERGE_W'(merge_d), MERGE_W'(merge_m)));

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (any_acc) begin
      q_r <= q_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_upd_r <= 1'b0;
    end else begin
      q_upd_r <= any_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_r <= GNT_B;
    end else if (ovl) begin
      last_gnt_r <= (last_gnt_r == GNT_B) ? GNT_A : GNT_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_r <= '0;
    end else if (ovl && (conflict_cnt_r != '1)) begin
      conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
    end
  end

  assign a_ready      = a_rdy;
  assign b_ready      = b_rdy;
  assign q            = q_r;
  assign q_upd        = q_upd_r;
  assign last_gnt     = last_gnt_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_masked_write_arbiter.sv
// Self-checking bench: behavioural model of the shared register checked every
// cycle, plus directed scenarios with literal expectations.
module tb_masked_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0;
  logic [3:0] a_data = '0;
  logic [3:0] a_mask = '0;
  logic       b_valid = 1'b0;
  logic [3:0] b_data = '0;
  logic [3:0] b_mask = '0;

  logic       a_ready, b_ready, q_upd, last_gnt;
  logic [3:0] q;
  logic [7:0] conflict_cnt;

  logic       s_a_ready, s_b_ready, s_q_upd, s_last_gnt;
  logic [3:0] s_q;
  logic [1:0] s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  masked_write_arbiter #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_mask(a_mask), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_mask(b_mask), .b_ready(b_ready),
    .q(q), .q_upd(q_upd), .last_gnt(last_gnt), .conflict_cnt(conflict_cnt)
  );

  masked_write_arbiter #(.W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_mask(a_mask), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_mask(b_mask), .b_ready(s_b_ready),
    .q(s_q), .q_upd(s_q_upd), .last_gnt(s_last_gnt), .conflict_cnt(s_conflict_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state of the shared register as the rules define it.
  logic [3:0] mq = '0;
  bit         mupd = 0;
  bit         mlast = 1;
  int         mcnt8 = 0;
  int         mcnt2 = 0;
  bit         model_ok = 0;

  function automatic void exp_ready(output bit ea, output bit eb);
    bit both_want_bit;
    both_want_bit = 0;
    for (int i = 0; i < 4; i++)
      if (a_mask[i] && b_mask[i]) both_want_bit = 1;
    ea = a_valid;
    eb = b_valid;
    if (a_valid && b_valid && both_want_bit) begin
      // The side that did not win last time goes first.
      if (mlast) eb = 0;
      else       ea = 0;
    end
    if (rst) begin
      ea = 0;
      eb = 0;
    end
  endfunction

  always @(posedge clk) begin
    bit ea, eb;
    exp_ready(ea, eb);
    if (rst) begin
      mq = '0; mupd = 0; mlast = 1; mcnt8 = 0; mcnt2 = 0; model_ok = 1;
    end else begin
      mupd = ea || eb;
      for (int i = 0; i < 4; i++) begin
        if (ea && a_mask[i]) mq[i] = a_data[i];
        if (eb && b_mask[i]) mq[i] = b_data[i];
      end
      if (a_valid && b_valid && ((a_mask & b_mask) != 0)) begin
        mlast = ea ? 0 : 1;
        if (mcnt8 < 255) mcnt8++;
        if (mcnt2 < 3)   mcnt2++;
      end
    end
  end

  always @(negedge clk) begin
    bit ea, eb;
    if (model_ok) begin
      exp_ready(ea, eb);
      check("q",            q,              mq);
      check("q_upd",        q_upd,          mupd);
      check("last_gnt",     last_gnt,       mlast);
      check("conflict_cnt", conflict_cnt,   mcnt8);
      check("a_ready",      a_ready,        ea);
      check("b_ready",      b_ready,        eb);
      check("sat_q",        s_q,            mq);
      check("sat_cnt",      s_conflict_cnt, mcnt2);
      check("sat_last_gnt", s_last_gnt,     mlast);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input logic [3:0] ad, input logic [3:0] am,
                       input bit bv, input logic [3:0] bd, input logic [3:0] bm);
    a_valid = av; a_data = ad; a_mask = am;
    b_valid = bv; b_data = bd; b_mask = bm;
  endtask

  initial begin
    bit acc_a, acc_b;

    // Reset with a request pending: ready must stay low.
    rst = 1;
    drive(1, 4'b0001, 4'b0001, 0, '0, '0);
    @(negedge clk);
    check("t1_a_ready", a_ready, 0);
    step();
    step();
    @(negedge clk);
    check("t1_q", q, 0);
    check("t1_q_upd", q_upd, 0);
    check("t1_cnt", conflict_cnt, 0);
    check("t1_last_gnt", last_gnt, 1);

    // Disjoint merge.
    step();
    rst = 0;
    drive(1, 4'b0011, 4'b0011, 1, 4'b1100, 4'b1100);
    @(negedge clk);
    check("t2_a_ready", a_ready, 1);
    check("t2_b_ready", b_ready, 1);
    step();
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    check("t2_q", q, 4'b1111);
    check("t2_q_upd", q_upd, 1);
    check("t2_cnt", conflict_cnt, 0);

    // Overlap rotation from a clean register.
    step();
    rst = 1;
    step();
    rst = 0;
    drive(1, 4'b0010, 4'b0110, 1, 4'b0100, 4'b0110);
    @(negedge clk);
    check("t3_c1_a_ready", a_ready, 1);
    check("t3_c1_b_ready", b_ready, 0);
    step();
    @(negedge clk);
    check("t3_c1_q", q, 4'b0010);
    check("t3_c1_last", last_gnt, 0);
    check("t3_c2_b_ready", b_ready, 1);
    step();
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    check("t3_c2_q", q, 4'b0100);
    check("t3_c2_last", last_gnt, 1);
    check("t3_cnt", conflict_cnt, 2);

    // Zero-mask write still pulses q_upd.
    step();
    drive(1, 4'b1010, 4'b1111, 0, '0, '0);
    step();
    drive(1, 4'b1111, 4'b0000, 0, '0, '0);
    @(negedge clk);
    check("t4_q_pre", q, 4'b1010);
    check("t4_a_ready", a_ready, 1);
    step();
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    check("t4_q", q, 4'b1010);
    check("t4_q_upd", q_upd, 1);
    step();
    @(negedge clk);
    check("t4_idle_q_upd", q_upd, 0);

    // Saturation of the narrow counter over five conflict cycles.
    step();
    rst = 1;
    step();
    rst = 0;
    drive(1, 4'b0101, 4'b1111, 1, 4'b1010, 4'b1111);
    repeat (4) @(posedge clk);
    step();
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    check("t5_sat_cnt", s_conflict_cnt, 3);
    check("t5_cnt", conflict_cnt, 5);
    check("t5_last", last_gnt, 0);
    check("t5_q", q, 4'b0101);
    step();
    @(negedge clk);
    check("t5_sat_hold", s_conflict_cnt, 3);

    // Reset while B is waiting on a conflict.
    step();
    rst = 1;
    step();
    rst = 0;
    drive(1, 4'b0010, 4'b0110, 1, 4'b0100, 4'b0110);
    @(negedge clk);
    check("t6_a_ready", a_ready, 1);
    check("t6_b_ready", b_ready, 0);
    step();
    rst = 1;
    @(negedge clk);
    check("t6_q_mid", q, 4'b0010);
    check("t6_b_ready_rst", b_ready, 0);
    step();
    rst = 0;
    @(negedge clk);
    check("t6_q_rst", q, 0);
    check("t6_last_rst", last_gnt, 1);
    check("t6_q_upd_rst", q_upd, 0);
    check("t6_a_first", a_ready, 1);
    check("t6_b_wait", b_ready, 0);
    step();
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    check("t6_q_after", q, 4'b0010);

    // Randomized traffic honouring hold-until-accepted.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 49) == 0);
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = 4'($urandom);
        a_mask  = 4'($urandom);
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data  = 4'($urandom);
        b_mask  = 4'($urandom);
      end
    end
    step();
    rst = 0;
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
